// File: rtl/spi_cmd_master_pkg.sv
// rtl/spi_cmd_master_pkg.sv - shared constants and FSM encoding for the SPI command master
package spi_cmd_master_pkg;

   localparam logic [15:0] CMD_IDLE    = 16'hFFFF;
   localparam logic [15:0] CMD_FIFO_WR = 16'h0101;
   localparam logic [15:0] CMD_FIFO_RD = 16'h0102;

   localparam int CLK_DIV_DEFAULT = 20;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_GAP   = 3'd3,
      S_HOLD  = 3'd4,
      S_DESEL = 3'd5
   } state_t;

endpackage

// File: rtl/spi_cmd_master_shifter.sv
// rtl/spi_cmd_master_shifter.sv - sclk divider, mode-0 word shifter and bit counter
module spi_master_shifter #(
   parameter int CLK_DIV = 20,
   parameter int WORD_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic              i_load,
   input  logic [WORD_W-1:0] i_load_word,
   input  logic              i_sclk_en,
   input  logic              i_miso,
   output logic              o_tick,
   output logic              o_sclk,
   output logic              o_mosi,
   output logic              o_rise,
   output logic              o_last_fall,
   output logic              o_word_done,
   output logic [WORD_W-1:0] o_rx_word
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(WORD_W + 1);

   logic [DIV_W-1:0]  r_div;
   logic [BIT_W-1:0]  r_bit;
   logic              r_sclk;
   logic [WORD_W-1:0] r_tx;
   logic [WORD_W-1:0] r_rx;
   logic              w_fall;

   assign o_tick      = (r_div == DIV_W'(CLK_DIV - 1));
   // r_bit counts completed falls; WORD_W means the word is out and only the trailing low half remains
   assign o_rise      = i_sclk_en & o_tick & ~r_sclk & (r_bit != BIT_W'(WORD_W));
   assign w_fall      = i_sclk_en & o_tick & r_sclk;
   assign o_last_fall = w_fall & (r_bit == BIT_W'(WORD_W - 1));
   assign o_word_done = i_sclk_en & o_tick & ~r_sclk & (r_bit == BIT_W'(WORD_W));
   assign o_sclk      = r_sclk;
   assign o_mosi      = r_tx[WORD_W-1];
   assign o_rx_word   = r_rx;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div  <= '0;
         r_bit  <= '0;
         r_sclk <= 1'b0;
         r_tx   <= '0;
         r_rx   <= '0;
      end else if (i_clr) begin
         r_div  <= '0;
         r_bit  <= '0;
         r_sclk <= 1'b0;
         r_tx   <= '0;
      end else if (i_load) begin
         r_div  <= '0;
         r_bit  <= '0;
         r_sclk <= 1'b0;
         r_tx   <= i_load_word;
      end else begin
         r_div <= o_tick ? '0 : r_div + DIV_W'(1);
         if (o_rise) begin
            r_sclk <= 1'b1;
            r_rx   <= {r_rx[WORD_W-2:0], i_miso};
         end
         if (w_fall) begin
            r_sclk <= 1'b0;
            r_bit  <= r_bit + BIT_W'(1);
            r_tx   <= {r_tx[WORD_W-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/spi_cmd_master.sv
// rtl/spi_cmd_master.sv - SPI initiator: command word plus nwords data words per transaction
module spi_cmd_master
   import spi_cmd_master_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT,
   parameter int WORD_W  = 16,
   parameter int CNT_W   = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [WORD_W-1:0] i_cmd,
   input  logic [CNT_W-1:0]  i_nwords,
   input  logic              i_abort,
   input  logic [WORD_W-1:0] i_wr_data,
   input  logic              i_wr_valid,
   output logic              o_wr_ready,
   output logic [WORD_W-1:0] o_rd_data,
   output logic              o_rd_valid,
   output logic              o_rd_is_cmd,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_sclk,
   output logic              o_ss,
   output logic              o_mosi,
   input  logic              i_miso
);

   state_t            r_state;
   logic [CNT_W-1:0]  r_words;
   logic              r_gap_armed;
   logic              r_slot_cmd;
   logic              r_ss;
   logic              r_busy;
   logic              r_done;
   logic              r_rd_valid;
   logic              r_rd_is_cmd;
   logic [WORD_W-1:0] r_rd_data;

   logic              w_accept;
   logic              w_take;
   logic              w_clr;
   logic              w_load;
   logic              w_sclk_en;
   logic [WORD_W-1:0] w_load_word;
   logic              w_tick;
   logic              w_rise;
   logic              w_last_fall;
   logic              w_word_done;
   logic [WORD_W-1:0] w_rx_word;

   assign w_accept    = (r_state == S_IDLE) & i_start & ~i_abort;
   assign w_take      = (r_state == S_GAP) & ~r_gap_armed & i_wr_valid & ~i_abort;
   assign w_clr       = i_abort | ((r_state == S_IDLE) & ~w_accept);
   assign w_load      = w_accept | w_take;
   assign w_load_word = (r_state == S_IDLE) ? i_cmd : i_wr_data;
   // sclk may only run while a word is in flight or armed to start
   assign w_sclk_en   = (r_state == S_SETUP) | (r_state == S_SHIFT) |
                        ((r_state == S_GAP) & r_gap_armed);

   assign o_wr_ready  = w_take;
   assign o_rd_data   = r_rd_data;
   assign o_rd_valid  = r_rd_valid;
   assign o_rd_is_cmd = r_rd_is_cmd;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_ss        = r_ss;

   spi_master_shifter #(
      .CLK_DIV (CLK_DIV),
      .WORD_W  (WORD_W)
   ) u_shifter (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_clr       (w_clr),
      .i_load      (w_load),
      .i_load_word (w_load_word),
      .i_sclk_en   (w_sclk_en),
      .i_miso      (i_miso),
      .o_tick      (w_tick),
      .o_sclk      (o_sclk),
      .o_mosi      (o_mosi),
      .o_rise      (w_rise),
      .o_last_fall (w_last_fall),
      .o_word_done (w_word_done),
      .o_rx_word   (w_rx_word)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_words     <= '0;
         r_gap_armed <= 1'b0;
         r_slot_cmd  <= 1'b0;
         r_ss        <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_is_cmd <= 1'b0;
         r_rd_data   <= '0;
      end else begin
         r_done      <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_is_cmd <= 1'b0;
         if (i_abort) begin
            r_state     <= S_IDLE;
            r_ss        <= 1'b1;
            r_busy      <= 1'b0;
            r_gap_armed <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (i_start) begin
                     r_state    <= S_SETUP;
                     r_ss       <= 1'b0;
                     r_busy     <= 1'b1;
                     r_words    <= i_nwords;
                     r_slot_cmd <= 1'b1;
                  end
               end
               S_SETUP: begin
                  if (w_rise) r_state <= S_SHIFT;
               end
               S_SHIFT: begin
                  if (w_last_fall) begin
                     r_rd_valid  <= 1'b1;
                     r_rd_data   <= w_rx_word;
                     r_rd_is_cmd <= r_slot_cmd;
                  end
                  if (w_word_done) begin
                     r_state     <= (r_words != '0) ? S_GAP : S_HOLD;
                     r_gap_armed <= 1'b0;
                  end
               end
               S_GAP: begin
                  if (!r_gap_armed) begin
                     if (i_wr_valid) begin
                        r_gap_armed <= 1'b1;
                        r_words     <= r_words - CNT_W'(1);
                        r_slot_cmd  <= 1'b0;
                     end
                  end else if (w_rise) begin
                     r_state     <= S_SHIFT;
                     r_gap_armed <= 1'b0;
                  end
               end
               S_HOLD: begin
                  if (w_tick) begin
                     r_state <= S_DESEL;
                     r_ss    <= 1'b1;
                  end
               end
               S_DESEL: begin
                  if (w_tick) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
